fifo_umbrales: RTL and testbench

Single-clock FIFO buffering 12-bit switch words (`[11:10]` class, `[9:8]` destination, `[7:0]` data) with programmable almost-full and almost-empty flags. One instance sits on each of the nine switch queues. It takes its threshold values from the control state machine's registered `fifos_full_threshold` and `fifos_empty_threshold` outputs. Its `empty` flag drives one bit of the controller's `fifos_empty[8:0]` bus, and the controller uses it to choose between IDLE and ACTIVE.

---
 rtl/switch_pkg.sv | 23 ++
 rtl/mem_2p.sv | 32 +++
 rtl/fifo_umbrales.sv | 81 ++++++++
 tb/tb_fifo_umbrales.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared switch definitions: word field positions, default FIFO geometry and queue count.
package switch_pkg;

  localparam int CLASS_MSB = 11;
  localparam int CLASS_LSB = 10;
  localparam int DEST_MSB  = 9;
  localparam int DEST_LSB  = 8;
  localparam int DATA_MSB  = 7;
  localparam int DATA_LSB  = 0;

  localparam int DEFAULT_WORD_SIZE = 12;
  localparam int DEFAULT_MEM_SIZE  = 8;
  localparam int DEFAULT_PTR       = 3;

  localparam int N_FIFOS = 9;

  typedef struct packed {
    logic [CLASS_MSB-CLASS_LSB:0] cls;
    logic [DEST_MSB-DEST_LSB:0]   dest;
    logic [DATA_MSB-DATA_LSB:0]   data;
  } switch_word_t;

endpackage

// File: rtl/mem_2p.sv
// Two-port register array: synchronous write, registered synchronous read.
module mem_2p #(
  parameter int WORD_SIZE = 12,
  parameter int MEM_SIZE  = 8,
  localparam int AW       = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [MEM_SIZE];

  // NOTE: the storage array has no reset; only the read register is cleared,
  // so the array can map onto plain registers or RAM without a clear path.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_umbrales.sv
// Single-clock switch-word FIFO with programmable almost-full / almost-empty flags.
module fifo_umbrales
  import switch_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int MEM_SIZE  = DEFAULT_MEM_SIZE,
  parameter int PTR       = DEFAULT_PTR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 pop,
  input  logic [PTR-1:0]       full_threshold,
  input  logic [PTR-1:0]       empty_threshold,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic [PTR:0]         count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error
);

  localparam logic [PTR:0] DEPTH = (PTR+1)'(MEM_SIZE);

  logic [PTR-1:0] wr_ptr, rd_ptr;
  logic           do_push, do_pop;
  logic [PTR:0]   full_level;
  logic [PTR:0]   count_next;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (do_pop && !do_push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      valid_out <= do_pop;
      error     <= (push && full) || (pop && empty);
    end
  end

  mem_2p #(
    .WORD_SIZE (WORD_SIZE),
    .MEM_SIZE  (MEM_SIZE)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (do_pop),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

  // A zero full threshold means "the whole depth", so almost_full then tracks full.
  assign full_level   = (full_threshold == '0) ? DEPTH : {1'b0, full_threshold};
  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= full_level);
  assign almost_empty = (count <= {1'b0, empty_threshold});

endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed self-checking bench for fifo_umbrales.
module tb_fifo_umbrales;

  logic        clk = 1'b0;
  logic        reset;
  logic        push, pop;
  logic [11:0] data_in;
  logic [2:0]  full_threshold, empty_threshold;
  logic [11:0] data_out;
  logic        valid_out;
  logic [3:0]  count;
  logic        full, empty, almost_full, almost_empty, error;

  int checks = 0;
  int errors = 0;

  fifo_umbrales dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .data_in         (data_in),
    .pop             (pop),
    .full_threshold  (full_threshold),
    .empty_threshold (empty_threshold),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .error           (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic [11:0] d);
    push = p; pop = q; data_in = d;
  endtask

  initial begin
    reset = 1'b0; drive(0, 0, 12'h000);
    full_threshold = 3'd6; empty_threshold = 3'd2;
    tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_aempty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_valid", valid_out, 0);
    check("rst_error", error, 0);
    check("rst_dout", data_out, 0);

    // Reset mid-stream, with requests held high during reset.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 12'hA01 + 12'(i)); tick();
    end
    drive(0, 1, 12'h000); tick();
    check("mid_pop_dout", data_out, 12'hA01);
    check("mid_pop_count", count, 2);
    reset = 1'b0; drive(1, 1, 12'hBBB); tick();
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_aempty", almost_empty, 1);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_dout", data_out, 0);
    reset = 1'b1;

    // Fill and overflow.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 12'(i)); tick();
      check("fill_count", count, i + 1);
      check("fill_afull", almost_full, int'(i + 1 >= 6));
      check("fill_full", full, int'(i + 1 == 8));
      check("fill_error", error, 0);
    end
    drive(1, 0, 12'h0EE); tick();
    check("ovf_error", error, 1);
    check("ovf_count", count, 8);
    drive(0, 0, 12'h000); tick();
    check("ovf_error_once", error, 0);

    // Drain, order and underflow.
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 12'h000); tick();
      check("drain_dout", data_out, i);
      check("drain_valid", valid_out, 1);
      check("drain_count", count, 7 - i);
      check("drain_aempty", almost_empty, int'(7 - i <= 2));
      check("drain_empty", empty, int'(i == 7));
    end
    drive(0, 1, 12'h000); tick();
    check("unf_error", error, 1);
    check("unf_valid", valid_out, 0);
    check("unf_dout_hold", data_out, 7);
    check("unf_count", count, 0);

    // Simultaneous push+pop when empty: push only.
    drive(1, 1, 12'h123); tick();
    check("sim_e_count", count, 1);
    check("sim_e_error", error, 1);
    check("sim_e_valid", valid_out, 0);
    drive(0, 1, 12'h000); tick();
    check("sim_e_dout", data_out, 12'h123);
    check("sim_e_error_clr", error, 0);

    // Simultaneous push+pop when full: pop only.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 12'h100 + 12'(i)); tick();
    end
    check("sim_f_full", full, 1);
    drive(1, 1, 12'h1FF); tick();
    check("sim_f_count", count, 7);
    check("sim_f_error", error, 1);
    check("sim_f_valid", valid_out, 1);
    check("sim_f_dout", data_out, 12'h100);
    for (int i = 1; i < 8; i++) begin
      drive(0, 1, 12'h000); tick();
      check("sim_f_drain", data_out, 12'h100 + i);
    end
    check("sim_f_empty", empty, 1);

    // Wrap-around at a steady level of 4.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 12'h200 + 12'(i)); tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 12'h204 + 12'(i)); tick();
      check("wrap_dout", data_out, 12'h200 + i);
      check("wrap_valid", valid_out, 1);
      check("wrap_count", count, 4);
      check("wrap_error", error, 0);
    end

    // Threshold edge cases.
    drive(0, 0, 12'h000); full_threshold = 3'd0; #1;
    check("thr0_at4", almost_full, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 12'h300 + 12'(i)); tick();
    end
    check("thr0_count7", count, 7);
    check("thr0_at7", almost_full, 0);
    drive(1, 0, 12'h303); tick();
    check("thr0_at8", almost_full, 1);
    check("thr0_full", full, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 12'h000); tick();
    end
    drive(0, 0, 12'h000);
    check("thr_count4", count, 4);
    empty_threshold = 3'd1; #1;
    check("ethr1_at4", almost_empty, 0);
    empty_threshold = 3'd5; #1;
    check("ethr5_at4", almost_empty, 1);
    full_threshold = 3'd3; #1;
    check("fthr3_at4", almost_full, 1);
    full_threshold = 3'd5; #1;
    check("fthr5_at4", almost_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
